// File: rtl/accumulator_unit.sv
// accumulator_unit
//   Sums a job of k_len beats of four unsigned column partial sums coming out
//   of the systolic array, then emits one registered, saturated result per
//   lane for the activation stage.
//
// Parameters
//   bit_width  lane width of the saturated results
//   acc_width  internal accumulator width per lane (wide enough for 255 beats)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle request to begin a job (ignored while busy)
//   k_len        number of beats in the job, sampled with start
//   psum_valid   qualifies psum1..psum4 (only honoured while accumulating)
//   psum1..4     unsigned partial sums, 2*bit_width bits each
//   busy         high while a job is accumulating or emitting
//   out1..4      saturated results, held until the next emit
//   out_valid    one-cycle pulse marking new out1..4 / sat
//   sat          per-lane saturation flags (bit0 = lane 1)
module accumulator_unit #(
    parameter int bit_width = 8,
    parameter int acc_width = 2*bit_width+8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             k_len,
    input  logic                   psum_valid,
    input  logic [2*bit_width-1:0] psum1,
    input  logic [2*bit_width-1:0] psum2,
    input  logic [2*bit_width-1:0] psum3,
    input  logic [2*bit_width-1:0] psum4,
    output logic                   busy,
    output logic [bit_width-1:0]   out1,
    output logic [bit_width-1:0]   out2,
    output logic [bit_width-1:0]   out3,
    output logic [bit_width-1:0]   out4,
    output logic                   out_valid,
    output logic [3:0]             sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [acc_width-1:0] sat_max =
        {{(acc_width-bit_width){1'b0}}, {bit_width{1'b1}}};

    state_t                 state;
    state_t                 state_nx;
    logic [7:0]             cnt;
    logic [acc_width-1:0]   acc   [4];
    logic [2*bit_width-1:0] psum  [4];
    logic [bit_width-1:0]   clamp [4];
    logic [3:0]             over;

    assign psum[0] = psum1;
    assign psum[1] = psum2;
    assign psum[2] = psum3;
    assign psum[3] = psum4;

    // busy follows the state, so it is already low in the cycle out_valid
    // pulses (the EMIT->IDLE edge produces both).
    assign busy = (state != IDLE);

    always_comb begin
        over = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            clamp[i] = '0;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            over[i]  = (acc[i] > sat_max);
            clamp[i] = over[i] ? '1 : acc[i][bit_width-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // an empty job skips accumulation and emits zeros
                    state_nx = (k_len == 8'd0) ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                if (psum_valid && (cnt == 8'd1)) begin
                    state_nx = EMIT;
                end
            end
            EMIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out4      <= '0;
            sat       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= k_len;
                        for (int unsigned i = 0; i < 4; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (psum_valid) begin
                        cnt <= cnt - 8'd1;
                        for (int unsigned i = 0; i < 4; i++) begin
                            acc[i] <= acc[i] + acc_width'(psum[i]);
                        end
                    end
                end
                EMIT: begin
                    out1      <= clamp[0];
                    out2      <= clamp[1];
                    out3      <= clamp[2];
                    out4      <= clamp[3];
                    sat       <= over;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_unit.sv
module tb_accumulator_unit;

    typedef struct packed {
        logic [3:0][7:0] o;
        logic [3:0]      s;
        int              due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  k_len;
    logic        psum_valid;
    logic [15:0] psum1, psum2, psum3, psum4;
    logic        busy;
    logic [7:0]  out1, out2, out3, out4;
    logic        out_valid;
    logic [3:0]  sat;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    accumulator_unit #(.bit_width(8), .acc_width(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .psum_valid(psum_valid),
        .psum1(psum1), .psum2(psum2), .psum3(psum3), .psum4(psum4),
        .busy(busy), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out_valid(out_valid), .sat(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every out_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got pulse expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out1", {24'd0, out1}, {24'd0, e.o[0]});
                check("out2", {24'd0, out2}, {24'd0, e.o[1]});
                check("out3", {24'd0, out3}, {24'd0, e.o[2]});
                check("out4", {24'd0, out4}, {24'd0, e.o[3]});
                check("sat", {28'd0, sat}, {28'd0, e.s});
                check("latency", cyc, e.due);
                check("busy_at_valid", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] k);
        start = 1'b1;
        k_len = k;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        psum_valid = 1'b1;
        psum1 = a; psum2 = b; psum3 = c; psum4 = d;
        tick();
        psum_valid = 1'b0;
    endtask

    // called right after the edge that accepted the last beat (or the start
    // of an empty job): the result is due one edge later
    task automatic expect_out(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [3:0] s);
        exp_t e;
        e.o[0] = a; e.o[1] = b; e.o[2] = c; e.o[3] = d;
        e.s    = s;
        e.due  = cyc + 1;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; psum_valid = 1'b0;
        psum1 = '0; psum2 = '0; psum3 = '0; psum4 = '0;
        repeat (3) tick();
        check("reset_out", {out1, out2, out3, out4}, 32'd0);
        check("reset_flags", {29'd0, sat == 4'd0, out_valid, busy}, 32'd4);
        rst_n = 1'b1;

        // three beats of (1,2,3,4), start on the first edge after reset
        do_start(8'd3);
        check("busy_accum", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) beat(16'd1, 16'd2, 16'd3, 16'd4);
        expect_out(8'd3, 8'd6, 8'd9, 8'd12, 4'b0000);
        drain("basic");
        repeat (3) tick();
        check("hold_out1", {24'd0, out1}, 32'd3);

        // lane 1 crosses 255 by one
        do_start(8'd2);
        beat(16'h00FF, 16'd0, 16'd0, 16'd0);
        beat(16'h0001, 16'd0, 16'd0, 16'd0);
        expect_out(8'hFF, 8'd0, 8'd0, 8'd0, 4'b0001);
        drain("sat_lane1");

        // exact boundary: 255 is not saturated, 256 is
        do_start(8'd1);
        beat(16'd255, 16'd256, 16'd0, 16'd100);
        expect_out(8'hFF, 8'hFF, 8'd0, 8'd100, 4'b0010);
        drain("boundary");

        // gaps of 0,3,1 cycles; a start inside a gap must be ignored
        do_start(8'd4);
        beat(16'd5, 16'd5, 16'd5, 16'd5);
        beat(16'd5, 16'd5, 16'd5, 16'd5);
        tick();
        do_start(8'd1);
        tick();
        beat(16'd5, 16'd5, 16'd5, 16'd5);
        tick();
        beat(16'd5, 16'd5, 16'd5, 16'd5);
        expect_out(8'd20, 8'd20, 8'd20, 8'd20, 4'b0000);
        drain("gaps");

        // empty job, with a start and psum_valid during EMIT that must be ignored
        do_start(8'd0);
        expect_out(8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
        psum_valid = 1'b1; psum1 = 16'd7;
        do_start(8'd3);
        psum_valid = 1'b0;
        check("ignored_start", {31'd0, busy}, 32'd0);
        tick();
        check("still_idle", {31'd0, busy}, 32'd0);
        drain("k0");

        // 255 beats of the maximum partial sum must not wrap
        do_start(8'd255);
        for (int i = 0; i < 255; i++) beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        expect_out(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF);
        drain("k255");

        // reset mid-job: outputs clear at once and the job never reports
        do_start(8'd5);
        beat(16'd3, 16'd3, 16'd3, 16'd3);
        beat(16'd3, 16'd3, 16'd3, 16'd3);
        rst_n = 1'b0;
        #1;
        check("midreset_out", {out1, out2, out3, out4}, 32'd0);
        check("midreset_flags", {29'd0, sat == 4'd0, out_valid, busy}, 32'd4);
        repeat (2) tick();
        rst_n = 1'b1;
        do_start(8'd1);
        beat(16'd9, 16'd9, 16'd9, 16'd9);
        expect_out(8'd9, 8'd9, 8'd9, 8'd9, 4'b0000);
        drain("after_reset");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
